// File: rtl/hwpe_stream_fault_collector_if.sv
// HWPE stream handshake interface: valid/ready with byte strobes.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, output data, output strb, input ready);
   modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_fault_collector.sv
// Collects copy-sink fault pulses into sticky flags, a saturating counter,
// an interrupt and a timestamped record log drained over an HWPE stream.
module hwpe_stream_fault_collector #(
   parameter int unsigned NB_SOURCES = 4,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  enable_i,
   input  logic [NB_SOURCES-1:0] fault_i,
   output logic [NB_SOURCES-1:0] fault_sticky_o,
   output logic [CNT_WIDTH-1:0]  fault_count_o,
   output logic                  overflow_o,
   output logic                  irq_o,
   hwpe_stream_intf_stream.source log_o
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned TS_W   = 16;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [TS_W-1:0]        timestamp;
      logic [DATA_W-TS_W-1:0] mask;
   } record_t;

   logic [NB_SOURCES-1:0] fault_sticky_q;
   logic [CNT_WIDTH-1:0]  fault_count_q;
   logic                  overflow_q;
   logic [TS_W-1:0]       timestamp_q;
   logic [PTR_W:0]        wr_ptr_q;
   logic [PTR_W:0]        rd_ptr_q;
   record_t               mem_q [FIFO_DEPTH];

   logic    flush_c;
   logic    event_c;
   logic    empty_c;
   logic    full_c;
   logic    pop_c;
   logic    push_c;
   logic    drop_c;
   record_t record_c;

   // Event qualification and FIFO handshake decode; all from registers or fault_i into state only.
   always_comb begin
      flush_c  = !rst_ni || clear_i;
      event_c  = enable_i && (|fault_i) && !clear_i;
      empty_c  = (wr_ptr_q == rd_ptr_q);
      full_c   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      pop_c    = !empty_c && log_o.ready;
      push_c   = event_c && (!full_c || pop_c);
      drop_c   = event_c && full_c && !pop_c;
      record_c = '{timestamp: timestamp_q, mask: (DATA_W-TS_W)'(fault_i)};
   end

   // Free-running timestamp, restarted by reset or clear.
   always_ff @(posedge clk_i) begin
      if (flush_c) begin
         timestamp_q <= '0;
      end else begin
         timestamp_q <= timestamp_q + TS_W'(1);
      end
   end

   // Status: sticky flags, saturating counter, sticky overflow.
   always_ff @(posedge clk_i) begin
      if (flush_c) begin
         fault_sticky_q <= '0;
         fault_count_q  <= '0;
         overflow_q     <= 1'b0;
      end else begin
         if (event_c) begin
            fault_sticky_q <= fault_sticky_q | fault_i;
            if (fault_count_q != {CNT_WIDTH{1'b1}}) begin
               fault_count_q <= fault_count_q + CNT_WIDTH'(1);
            end
         end
         if (drop_c) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Log FIFO pointers carry an extra wrap bit to tell full from empty.
   always_ff @(posedge clk_i) begin
      if (flush_c) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
         end
      end
   end

   // Storage needs no reset: the head is masked to zero whenever empty.
   always_ff @(posedge clk_i) begin
      if (!flush_c && push_c) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= record_c;
      end
   end

   assign fault_sticky_o = fault_sticky_q;
   assign fault_count_o  = fault_count_q;
   assign overflow_o     = overflow_q;
   assign irq_o          = |fault_sticky_q;

   assign log_o.valid = !empty_c;
   assign log_o.data  = empty_c ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign log_o.strb  = empty_c ? '0 : '1;

endmodule
